// File: rtl/mem_arbiter_2port.sv
// Round-robin arbiter/sequencer sharing one synchronous word memory between an
// instruction-fetch port (port 0, read-only) and a load/store port (port 1).
module mem_arbiter_2port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;       // port that wins a tie
    logic                  port_q, port_d;   // port owning the transaction in flight
    logic                  we_q, we_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  p0_ack_q, p0_ack_d;
    logic                  p1_ack_q, p1_ack_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
    logic                  busy_q, busy_d;

    logic                  elig0_s, elig1_s, grant1_s;

    // Eligibility and winner selection; the port being acked this cycle is masked
    always_comb begin
        elig0_s  = p0_req & ~p0_ack_q;
        elig1_s  = p1_req & ~p1_ack_q;
        grant1_s = elig1_s & (~elig0_s | rr_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        port_d      = port_q;
        we_d        = we_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig0_s | elig1_s) begin
                    port_d      = grant1_s;
                    we_d        = grant1_s & p1_we;
                    mem_read_d  = ~(grant1_s & p1_we);
                    mem_write_d = grant1_s & p1_we;
                    rr_d        = ~grant1_s;
                    busy_d      = 1'b1;
                    state_d     = ST_ISSUE;
                    if (grant1_s) begin
                        mem_addr_d  = p1_addr;
                        mem_wdata_d = p1_wdata;
                    end else begin
                        mem_addr_d  = p0_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                busy_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Memory output is valid now; hand it to the owner and ack
                state_d = ST_IDLE;
                if (port_q) begin
                    p1_ack_d = 1'b1;
                    if (!we_q) begin
                        p1_rdata_d = mem_rdata;
                    end else begin
                        p1_rdata_d = p1_rdata_q;
                    end
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            port_q      <= port_d;
            we_q        <= we_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Bench for mem_arbiter_2port: directed scenarios with literal expectations plus a
// transaction-age model that is compared against every output on every cycle.
module tb_mem_arbiter_2port;

    logic        CLK, RST;
    logic        p0_req, p1_req, p1_we;
    logic [25:0] p0_addr, p1_addr;
    logic [31:0] p1_wdata;
    logic        p0_ack, p1_ack, mem_read, mem_write, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [25:0] mem_addr;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter_2port #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Synchronous memory: sampled on the closing edge of the strobe cycle
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    always @(posedge CLK) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
    end

    // Model: one transaction at a time, tracked by its age in cycles since the grant
    logic        m_active, m_port, m_we, m_rr;
    logic [1:0]  m_age;
    logic [25:0] m_addr, e_addr;
    logic [31:0] m_wdata, e_wdata, e_rd0, e_rd1;
    wire m_free  = !m_active || (m_age >= 2'd2);
    wire m_el0   = p0_req && !(m_active && m_age == 2'd2 && !m_port);
    wire m_el1   = p1_req && !(m_active && m_age == 2'd2 && m_port);
    wire m_pick  = (m_el0 && m_el1) ? m_rr : m_el1;
    wire m_grant = m_free && (m_el0 || m_el1);
    wire e_read  = m_active && m_age == 2'd0 && !m_we;
    wire e_write = m_active && m_age == 2'd0 && m_we;
    wire e_busy  = m_active && m_age < 2'd2;
    wire e_ack0  = m_active && m_age == 2'd2 && !m_port;
    wire e_ack1  = m_active && m_age == 2'd2 && m_port;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_active <= 1'b0; m_port <= 1'b0; m_we <= 1'b0; m_rr <= 1'b0; m_age <= 2'd0;
            m_addr <= 26'd0; m_wdata <= 32'd0; e_addr <= 26'd0; e_wdata <= 32'd0;
            e_rd0 <= 32'd0; e_rd1 <= 32'd0;
        end else begin
            if (m_active && m_age == 2'd0 && m_we) ref_mem[m_addr[7:0]] <= m_wdata;
            if (m_active && m_age == 2'd1 && !m_we) begin
                if (m_port) e_rd1 <= ref_mem[m_addr[7:0]];
                else        e_rd0 <= ref_mem[m_addr[7:0]];
            end
            if (m_grant) begin
                m_active <= 1'b1;
                m_age    <= 2'd0;
                m_port   <= m_pick;
                m_we     <= m_pick && p1_we;
                m_addr   <= m_pick ? p1_addr : p0_addr;
                e_addr   <= m_pick ? p1_addr : p0_addr;
                m_wdata  <= p1_wdata;
                if (m_pick) e_wdata <= p1_wdata;
                m_rr     <= !m_pick;
            end else if (m_active && m_age != 2'd3) begin
                m_age <= m_age + 2'd1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (RST) begin
            chk("mem_read", mem_read, e_read);
            chk("mem_write", mem_write, e_write);
            chk("rw_excl", mem_read & mem_write, 1'b0);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("busy", busy, e_busy);
            chk("p0_ack", p0_ack, e_ack0);
            chk("p1_ack", p1_ack, e_ack1);
            chk("p0_rdata", p0_rdata, e_rd0);
            chk("p1_rdata", p1_rdata, e_rd1);
        end
    end

    task automatic wait_ack(input int port, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge CLK); #1;
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int nack;
        logic exp_port;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        RST = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
        p0_addr = 26'd0; p1_addr = 26'd0; p1_wdata = 32'd0;
        #1;
        chk("reset_outs", {p0_ack, p1_ack, mem_read, mem_write, busy, mem_addr, mem_wdata,
                           p0_rdata, p1_rdata}, 64'd0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;

        // 1: p0 read of preloaded word
        @(negedge CLK);
        p0_req = 1'b1; p0_addr = 26'h10;
        @(posedge CLK); #1;
        chk("t1_read_hi", {mem_read, mem_write, busy}, 3'b101);
        chk("t1_addr", mem_addr, 26'h10);
        @(posedge CLK); #1;
        chk("t1_read_lo", {mem_read, busy, p0_ack}, 3'b010);
        @(posedge CLK); #1;
        chk("t1_ack", {p0_ack, busy}, 2'b10);
        chk("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        @(negedge CLK);
        p0_req = 1'b0;
        @(posedge CLK); #1;
        chk("t1_ack_one_cycle", p0_ack, 1'b0);

        // Request dropped before its ack still completes
        @(negedge CLK);
        p0_req = 1'b1; p0_addr = 26'h21;
        @(posedge CLK); #1;
        @(negedge CLK);
        p0_req = 1'b0; p0_addr = 26'h3F;
        wait_ack(0, 6, lat);
        chk("early_drop_lat", lat, 2);
        chk("early_drop_rdata", p0_rdata, 32'hA500_0021);

        // 2: p1 write then p0 read of the same word
        @(negedge CLK);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 26'h20; p1_wdata = 32'h1234_5678;
        @(posedge CLK); #1;
        chk("t2_write_hi", {mem_write, mem_read}, 2'b10);
        chk("t2_wdata", mem_wdata, 32'h1234_5678);
        @(posedge CLK); #1;
        chk("t2_write_lo", mem_write, 1'b0);
        @(posedge CLK); #1;
        chk("t2_p1_ack", p1_ack, 1'b1);
        chk("t2_p1_rdata", p1_rdata, 32'd0);
        @(negedge CLK);
        p1_req = 1'b0; p1_we = 1'b0; p0_req = 1'b1; p0_addr = 26'h20;
        wait_ack(0, 6, lat);
        chk("t2_p0_lat", lat, 3);
        chk("t2_p0_rdata", p0_rdata, 32'h1234_5678);
        chk("t2_model_rd0", e_rd0, 32'h1234_5678);
        @(negedge CLK);
        p0_req = 1'b0;

        // 3: simultaneous requests after reset, p0 wins first
        do_reset();
        p0_req = 1'b1; p0_addr = 26'h30;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 26'h40;
        @(posedge CLK); #1;
        chk("t3_first_addr", mem_addr, 26'h30);
        @(posedge CLK); @(posedge CLK); #1;
        chk("t3_p0_ack", {p0_ack, p1_ack}, 2'b10);
        chk("t3_p0_rdata", p0_rdata, 32'hA500_0030);
        @(negedge CLK);
        p0_req = 1'b0;
        wait_ack(1, 6, lat);
        chk("t3_ack_gap", lat, 3);
        chk("t3_p1_rdata", p1_rdata, 32'hA500_0040);
        chk("t3_model_rd1", e_rd1, 32'hA500_0040);
        @(negedge CLK);
        p1_req = 1'b0;
        @(negedge CLK);

        // 4: both held for 12 transactions; strict alternation starting at p0
        p0_req = 1'b1; p0_addr = 26'h05;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 26'h06;
        nack = 0; exp_port = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            @(posedge CLK); #1;
            if (p0_ack || p1_ack) begin
                nack++;
                chk("t4_alt", {p0_ack, p1_ack}, exp_port ? 2'b01 : 2'b10);
                chk("t4_spacing", i % 3, 0);
                exp_port = ~exp_port;
            end
        end
        chk("t4_count", nack, 12);
        @(negedge CLK);
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge CLK); @(negedge CLK); @(negedge CLK);

        // 5: reset during ISSUE of a p1 write
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 26'h50; p1_wdata = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        chk("t5_issue", mem_write, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("t5_reset_outs", {p0_ack, p1_ack, mem_read, mem_write, busy, mem_addr, mem_wdata,
                              p0_rdata, p1_rdata}, 64'd0);
        @(posedge CLK); #1;
        chk("t5_no_ack", p1_ack, 1'b0);
        chk("t5_not_written", mem[8'h50], 32'hA500_0050);
        @(negedge CLK);
        RST = 1'b1;
        wait_ack(1, 6, lat);
        chk("t5_regrant_lat", lat, 3);
        chk("t5_written", mem[8'h50], 32'hCAFE_F00D);
        @(negedge CLK);
        p1_req = 1'b0; p1_we = 1'b0;

        // 6: random traffic checked by the per-cycle model
        for (int c = 0; c < 10000; c++) begin
            @(negedge CLK);
            if (p0_req && p0_ack) p0_req = 1'b0;
            else if (!p0_req && $urandom_range(0, 3) == 0) begin
                p0_req = 1'b1; p0_addr = 26'($urandom_range(0, 255));
            end
            if (p1_req && p1_ack) p1_req = 1'b0;
            else if (!p1_req && $urandom_range(0, 2) == 0) begin
                p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
                p1_addr = 26'($urandom_range(0, 255)); p1_wdata = $urandom;
            end
        end
        @(negedge CLK);
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (6) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
